// File: rtl/noop_trap_collector.sv
// Commit-side cycle/instruction collector for the simulation monitor.
// Reports a NOOP trap or commit deadlock once, then freezes until reset.
module noop_trap_collector #(
    parameter int          COMMIT_W     = 2,
    parameter int          TIMEOUT      = 5000,
    parameter logic [31:0] TIMEOUT_CODE = 32'h0000_0002
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [COMMIT_W-1:0]   commit_valid,
    input  logic [32*COMMIT_W-1:0] commit_pc,
    input  logic [COMMIT_W-1:0]   commit_is_trap,
    input  logic [31:0]           trap_a0,
    output logic                  isNoopTrap,
    output logic [31:0]           trapCode,
    output logic [31:0]           trapPC,
    output logic [31:0]           cycleCnt,
    output logic [31:0]           instrCnt,
    output logic                  halted
);

    localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        REPORT = 2'd1,
        HALT   = 2'd2
    } state_t;

    state_t state, stateNext;

    logic [31:0]       lastPc, lastPcNext;
    logic [IDLE_W-1:0] idleCnt, idleNext, idleInc;

    logic              isNoopTrapNext, haltedNext;
    logic [31:0]       trapCodeNext, trapPCNext;
    logic [31:0]       cycleNext, instrNext;

    logic                trapSeen;
    logic [COMMIT_W-1:0] countMask;
    logic [31:0]         retireCnt;
    logic [31:0]         youngPc;
    logic [31:0]         trapPcSel;
    logic                anyCommit;
    logic                timeoutHit;

    // Walk slots oldest-first; the first trap closes the window, so
    // everything younger is neither counted nor used for last_pc.
    always_comb begin
        trapSeen  = 1'b0;
        countMask = '0;
        retireCnt = '0;
        youngPc   = lastPc;
        trapPcSel = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            countMask[i] = commit_valid[i] & ~trapSeen;
            retireCnt    = retireCnt + 32'(countMask[i]);
            if (countMask[i]) begin
                youngPc = commit_pc[32*i +: 32];
            end
            if (countMask[i] && commit_is_trap[i]) begin
                trapSeen  = 1'b1;
                trapPcSel = commit_pc[32*i +: 32];
            end
        end
    end

    assign anyCommit  = |commit_valid;
    assign idleInc    = idleCnt + 1'b1;
    assign timeoutHit = (TIMEOUT != 0) && !anyCommit
                        && (idleInc == IDLE_W'(TIMEOUT));

    always_comb begin
        stateNext      = state;
        isNoopTrapNext = isNoopTrap;
        trapCodeNext   = trapCode;
        trapPCNext     = trapPC;
        cycleNext      = cycleCnt;
        instrNext      = instrCnt;
        haltedNext     = halted;
        lastPcNext     = lastPc;
        idleNext       = idleCnt;
        unique case (state)
            RUN: begin
                cycleNext = cycleCnt + 32'd1;
                instrNext = instrCnt + retireCnt;
                if (anyCommit) begin
                    lastPcNext = youngPc;
                    idleNext   = '0;
                end else if (TIMEOUT != 0) begin
                    idleNext = idleInc;
                end
                if (trapSeen) begin
                    trapCodeNext   = trap_a0;
                    trapPCNext     = trapPcSel;
                    isNoopTrapNext = 1'b1;
                    stateNext      = REPORT;
                end else if (timeoutHit) begin
                    trapCodeNext   = TIMEOUT_CODE;
                    trapPCNext     = lastPc;
                    isNoopTrapNext = 1'b1;
                    stateNext      = REPORT;
                end
            end
            REPORT: begin
                isNoopTrapNext = 1'b0;
                haltedNext     = 1'b1;
                stateNext      = HALT;
            end
            HALT: begin
                stateNext = HALT;
            end
            default: begin
                stateNext = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            isNoopTrap <= 1'b0;
            trapCode   <= '0;
            trapPC     <= '0;
            cycleCnt   <= '0;
            instrCnt   <= '0;
            halted     <= 1'b0;
            lastPc     <= '0;
            idleCnt    <= '0;
        end else begin
            state      <= stateNext;
            isNoopTrap <= isNoopTrapNext;
            trapCode   <= trapCodeNext;
            trapPC     <= trapPCNext;
            cycleCnt   <= cycleNext;
            instrCnt   <= instrNext;
            halted     <= haltedNext;
            lastPc     <= lastPcNext;
            idleCnt    <= idleNext;
        end
    end

endmodule

// File: tb/tb_noop_trap_collector.sv
// Scoreboard bench for noop_trap_collector (COMMIT_W=2, TIMEOUT=8).
// Expected reports are queued by stimulus and popped by a pulse monitor.
module tb_noop_trap_collector;

    logic        clk;
    logic        rst_n;
    logic [1:0]  commit_valid;
    logic [63:0] commit_pc;
    logic [1:0]  commit_is_trap;
    logic [31:0] trap_a0;
    logic        isNoopTrap;
    logic [31:0] trapCode;
    logic [31:0] trapPC;
    logic [31:0] cycleCnt;
    logic [31:0] instrCnt;
    logic        halted;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] code;
        logic [31:0] pc;
        logic [31:0] cyc;
        logic [31:0] instr;
    } rep_t;

    rep_t expQ[$];

    noop_trap_collector #(
        .COMMIT_W    (2),
        .TIMEOUT     (8),
        .TIMEOUT_CODE(32'h0000_0002)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .commit_valid  (commit_valid),
        .commit_pc     (commit_pc),
        .commit_is_trap(commit_is_trap),
        .trap_a0       (trap_a0),
        .isNoopTrap    (isNoopTrap),
        .trapCode      (trapCode),
        .trapPC        (trapPC),
        .cycleCnt      (cycleCnt),
        .instrCnt      (instrCnt),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every sampled pulse must match the oldest queued report.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && isNoopTrap === 1'b1) begin
            if (expQ.size() == 0) begin
                chk("unexpected_pulse", 32'(isNoopTrap), 32'd0);
            end else begin
                rep_t e;
                e = expQ.pop_front();
                chk("rep_code", trapCode, e.code);
                chk("rep_pc", trapPC, e.pc);
                chk("rep_cycles", cycleCnt, e.cyc);
                chk("rep_instrs", instrCnt, e.instr);
            end
        end
    end

    task automatic drive(input logic [1:0] v, input logic [1:0] t,
                         input logic [31:0] pc0, input logic [31:0] pc1,
                         input logic [31:0] a0);
        commit_valid   = v;
        commit_is_trap = t;
        commit_pc      = {pc1, pc0};
        trap_a0        = a0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(2'b00, 2'b00, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic doReset();
        rst_n          = 1'b0;
        commit_valid   = '0;
        commit_is_trap = '0;
        commit_pc      = '0;
        trap_a0        = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic checkZero(input string tag);
        chk({tag, "_pulse"}, 32'(isNoopTrap), 32'd0);
        chk({tag, "_code"}, trapCode, 32'd0);
        chk({tag, "_pc"}, trapPC, 32'd0);
        chk({tag, "_cycles"}, cycleCnt, 32'd0);
        chk({tag, "_instrs"}, instrCnt, 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
    endtask

    task automatic checkDrained(input string tag);
        chk({tag, "_missing_reports"}, 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rep_t r;

        // Reset state and idle counting
        doReset();
        checkZero("reset");
        idle(5);
        chk("idle_cycles", cycleCnt, 32'd5);
        chk("idle_instrs", instrCnt, 32'd0);

        // Single-slot run ending in a trap at 0x8000_0024
        doReset();
        for (int k = 1; k <= 10; k++)
            drive(2'b01, 2'b00, 32'h8000_0000 + 32'(4 * (k - 1)), 32'd0, 32'd0);
        r = '{code: 32'd0, pc: 32'h8000_0024, cyc: 32'd11, instr: 32'd11};
        expQ.push_back(r);
        drive(2'b01, 2'b01, 32'h8000_0024, 32'd0, 32'd0);
        chk("single_pulse_high", 32'(isNoopTrap), 32'd1);
        idle(1);
        chk("single_pulse_low", 32'(isNoopTrap), 32'd0);
        chk("single_halted", 32'(halted), 32'd1);
        checkDrained("single");

        // Older normal slot counted, trap in slot 1
        doReset();
        drive(2'b11, 2'b00, 32'h0000_00f8, 32'h0000_00fc, 32'd0);
        r = '{code: 32'd1, pc: 32'h0000_0104, cyc: 32'd2, instr: 32'd4};
        expQ.push_back(r);
        drive(2'b11, 2'b10, 32'h0000_0100, 32'h0000_0104, 32'd1);
        idle(2);
        checkDrained("dual_slot1");

        // Both slots trap: oldest wins, younger slot not counted
        doReset();
        drive(2'b01, 2'b00, 32'h0000_01fc, 32'd0, 32'd0);
        r = '{code: 32'd5, pc: 32'h0000_0200, cyc: 32'd2, instr: 32'd2};
        expQ.push_back(r);
        drive(2'b11, 2'b11, 32'h0000_0200, 32'h0000_0204, 32'd5);
        idle(2);
        checkDrained("dual_both");

        // Deadlock timeout after 8 idle cycles
        doReset();
        drive(2'b01, 2'b00, 32'h8000_0100, 32'd0, 32'd0);
        r = '{code: 32'd2, pc: 32'h8000_0100, cyc: 32'd9, instr: 32'd1};
        expQ.push_back(r);
        idle(7);
        chk("timeout_not_early", 32'(isNoopTrap), 32'd0);
        idle(1);
        chk("timeout_pulse", 32'(isNoopTrap), 32'd1);
        idle(1);
        checkDrained("timeout");

        // Halted: inputs ignored, fields frozen, no second pulse
        for (int k = 0; k < 20; k++)
            drive(2'b11, (k % 2 == 0) ? 2'b01 : 2'b10,
                  32'h0000_4000 + 32'(8 * k), 32'h0000_4004 + 32'(8 * k),
                  32'h0000_0099);
        chk("halt_code", trapCode, 32'd2);
        chk("halt_pc", trapPC, 32'h8000_0100);
        chk("halt_cycles", cycleCnt, 32'd9);
        chk("halt_instrs", instrCnt, 32'd1);
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_pulse", 32'(isNoopTrap), 32'd0);

        // Reset asserted in the middle of the report cycle
        doReset();
        r = '{code: 32'd7, pc: 32'h0000_0300, cyc: 32'd1, instr: 32'd1};
        expQ.push_back(r);
        drive(2'b01, 2'b01, 32'h0000_0300, 32'd0, 32'd7);
        chk("midrep_pulse_high", 32'(isNoopTrap), 32'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkZero("midrep");
        checkDrained("midrep");
        commit_valid   = '0;
        commit_is_trap = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3);
        chk("restart_cycles", cycleCnt, 32'd3);
        chk("restart_instrs", instrCnt, 32'd0);
        chk("restart_halted", 32'(halted), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/noop_trap_collector.md
# noop_trap_collector

Commit-side collector that feeds the simulation monitor. It counts elapsed cycles and retired instructions from the commit stage and detects the NOOP trap instruction or a commit deadlock. On detection it emits a single registered report (isNoopTrap, trapCode, trapPC, cycleCnt, instrCnt) and then halts in a frozen state until reset.

## Interface
- COMMIT_W, 2: commit slots per cycle (1..4); slot 0 is oldest.
- TIMEOUT, 5000: consecutive commit-free RUN cycles before a deadlock trap. 0 disables the timeout.
- TIMEOUT_CODE, 32'h0000_0002: trapCode reported on a deadlock trap.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
- commit_valid  in  COMMIT_W  slot i retires an instruction this cycle.
- commit_pc  in  32*COMMIT_W  PC of slot i at bits [32i+31:32i].
- commit_is_trap  in  COMMIT_W  slot i is the NOOP trap instruction; qualified by commit_valid[i].
- trap_a0  in  32  a0 value belonging to the oldest trapping slot this cycle.
- isNoopTrap  out  1  one-cycle report pulse.
- trapCode  out  32  latched trap code.
- trapPC  out  32  latched trap PC.
- cycleCnt  out  32  RUN cycles elapsed.
- instrCnt  out  32  instructions retired.
- halted  out  1  high in HALT.

## Operation
- States: RUN, REPORT, HALT. Reset enters RUN. All outputs reset to 0, and so do last_pc and the idle counter.
- RUN, every cycle:
  - cycleCnt += 1.
  - Trap slot t = lowest i with commit_valid[i] & commit_is_trap[i].
  - instrCnt += popcount of valid slots 0..t when a trap slot exists; otherwise popcount of all valid slots.
  - Slots younger than t are ignored entirely: not counted, PC not used.
  - last_pc takes the PC of the youngest counted valid slot.
  - Idle counter clears on any valid commit and increments otherwise.
- Trap found: trapCode<=trap_a0, trapPC<=commit_pc[t], isNoopTrap<=1, next state REPORT.
- Timeout: with no commit, when the idle counter would reach TIMEOUT (TIMEOUT≠0), trapCode<=TIMEOUT_CODE, trapPC<=last_pc, isNoopTrap<=1, next state REPORT.
  - A timeout and a trap commit in the same cycle are impossible by construction.
- REPORT: lasts exactly one cycle with isNoopTrap=1. All counters and trap fields are frozen. Next state HALT; isNoopTrap<=0, halted<=1.
- HALT: all outputs hold; commit inputs are ignored; no further pulses. Exit only via rst_n.
- Arithmetic: cycleCnt and instrCnt wrap modulo 2^32 without flagging. The idle counter is sized clog2(TIMEOUT+1) and never wraps.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- A trap in RUN cycle T makes isNoopTrap=1 in cycle T+1. In that cycle, cycleCnt includes cycle T and instrCnt includes the trap instruction.
- isNoopTrap is high for exactly one cycle per reset epoch.
- rst_n low: outputs clear immediately, independent of clk, including mid-REPORT where the pulse is truncated. The first RUN count occurs on the first rising edge after deassertion.
- The monitor samples on posedge clk while isNoopTrap=1. Fields are stable for the whole REPORT cycle and remain stable through HALT.

## Test plan
- Reset: hold rst_n low 3 cycles, then release -> all outputs 0, halted=0; after 5 idle cycles, cycleCnt=5, instrCnt=0.
- Single-slot run:
  - Stimulus: commits in cycles 1..10, then a trap in slot 0 in cycle 11 with a0=0, pc=0x8000_0024.
  - Required: cycle 12 has isNoopTrap=1, trapCode=0, trapPC=0x8000_0024, cycleCnt=11, instrCnt=11; cycle 13 has isNoopTrap=0, halted=1.
- Dual-slot ordering:
  - Stimulus: slot0 is a normal instruction at pc 0x100; slot1 is a trap with a0=1 at pc 0x104.
  - Required: instrCnt+2, trapPC=0x104, trapCode=1.
  - Stimulus: both slots are traps at pcs 0x200 and 0x204.
  - Required: trapPC=0x200, instrCnt+1.
- Timeout with TIMEOUT=8:
  - Stimulus: last commit at pc 0x8000_0100, then no commits.
  - Required: isNoopTrap pulses in the cycle after the 8th idle cycle, with trapCode=2, trapPC=0x8000_0100.
- Post-halt: after HALT, drive 20 cycles of valid commits and traps -> cycleCnt, instrCnt and trap fields unchanged; no second pulse.
- Reset mid-REPORT: drop rst_n during the pulse cycle -> isNoopTrap falls before the next edge and all outputs are 0; after release, counting restarts from 0 in RUN.
